// File: rtl/top_adder_accumulator.sv
// Purpose : 8-bit operand register feeding a 16-bit wrapping accumulator, shown on a 4-digit hex display.
// Latency : A/ACC update on the same MCLK edge that detects a button press; Led and seg are combinational.
// Backpr. : none; one event per press, and a button still held across reset must be released before it counts.
//
// Ports:
//   MCLK      sole clock, rising edge
//   btn[3:0]  btn[0] async active-high reset, btn[1] LOAD, btn[2] ADD, btn[3] unused
//   sw[7:0]   operand switches, captured into A on LOAD
//   Led[7:0]  operand register A
//   seg[6:0]  active-low cathodes of the selected digit (seg[0]=a .. seg[6]=g)
//   an[3:0]   active-low digit anodes, an[0] = rightmost digit
//   dp        active-low decimal point, always off
module top_adder_accumulator #(
    parameter int SCAN_BITS = 16
) (
    input  logic       MCLK,
    input  logic [3:0] btn,
    input  logic [7:0] sw,
    output logic [7:0] Led,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int CW = SCAN_BITS + 2;

    logic          rst;
    logic          unused_btn;
    logic [7:0]    a;
    logic [15:0]   acc;
    logic [CW-1:0] scan_cnt;
    logic          load_q;
    logic          add_q;
    // Set by reset; a button must be seen released once before it can
    // generate an event, so a press held through reset is ignored.
    logic          load_blk;
    logic          add_blk;
    logic          load_ev;
    logic          add_ev;
    logic [1:0]    digit;
    logic [3:0]    nibble;

    assign rst        = btn[0];
    assign unused_btn = btn[3];

    assign load_ev = btn[1] & ~load_q & ~load_blk;
    assign add_ev  = btn[2] & ~add_q  & ~add_blk;

    always_ff @(posedge MCLK or posedge rst) begin
        if (rst) begin
            a        <= 8'h00;
            acc      <= 16'h0000;
            scan_cnt <= '0;
            load_q   <= 1'b0;
            add_q    <= 1'b0;
            load_blk <= 1'b1;
            add_blk  <= 1'b1;
        end else begin
            scan_cnt <= scan_cnt + CW'(1);
            load_q   <= btn[1];
            add_q    <= btn[2];
            if (!btn[1]) begin
                load_blk <= 1'b0;
            end
            if (!btn[2]) begin
                add_blk <= 1'b0;
            end
            // LOAD takes priority; a coincident ADD is dropped.
            if (load_ev) begin
                a <= sw;
            end else if (add_ev) begin
                acc <= acc + {8'h00, a};
            end
        end
    end

    assign Led    = a;
    assign dp     = 1'b1;
    assign digit  = scan_cnt[CW-1:SCAN_BITS];
    assign an     = ~(4'b0001 << digit);
    assign nibble = acc[{digit, 2'b00} +: 4];

    always_comb begin
        seg = 7'b1111111;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_top_adder_accumulator.sv
// Bench for top_adder_accumulator: directed button sequences, expected A/ACC
// queued when a press is driven and compared after the detecting edge.
module tb_top_adder_accumulator;

    localparam int SB = 2;

    logic       MCLK = 1'b0;
    logic [3:0] btn;
    logic [7:0] sw;
    logic [7:0] Led;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  m_a;
    logic [15:0] m_acc;

    top_adder_accumulator #(.SCAN_BITS(SB)) dut (
        .MCLK (MCLK),
        .btn  (btn),
        .sw   (sw),
        .Led  (Led),
        .seg  (seg),
        .an   (an),
        .dp   (dp)
    );

    always #5 MCLK = ~MCLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic tick();
        @(posedge MCLK);
        @(negedge MCLK);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Walk the scan through all four digits and compare each against exp.
    task automatic check_disp(input string tag, input logic [15:0] exp);
        for (int d = 0; d < 4; d++) begin
            logic [3:0] want;
            logic [3:0] nib;
            int n;
            want = ~(4'b0001 << d);
            nib  = exp[d*4 +: 4];
            n = 0;
            while (an !== want && n < 64) begin
                tick();
                n++;
            end
            check({tag, "_an"}, {12'h000, an}, {12'h000, want});
            check({tag, "_seg"}, {9'h000, seg}, {9'h000, hex7(nib)});
        end
        check({tag, "_dp"}, {15'h0000, dp}, 16'h0001);
    endtask

    task automatic do_reset();
        btn = 4'b0001;
        tick();
        btn = 4'b0000;
        tick();
        tick();
        m_a   = 8'h00;
        m_acc = 16'h0000;
    endtask

    // Drive a press of LOAD and/or ADD for hold clocks, queue the expected
    // state, then release and compare once the detecting edge has passed.
    task automatic press(input string tag, input logic ld, input logic ad,
                         input int hold, input bit disp);
        exp_t e;
        btn[1] = ld;
        btn[2] = ad;
        if (ld) m_a = sw;
        else if (ad) m_acc = m_acc + {8'h00, m_a};
        exp_q.push_back('{a: m_a, acc: m_acc});
        repeat (hold) tick();
        btn[1] = 1'b0;
        btn[2] = 1'b0;
        tick();
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 16'h0000, 16'h0001);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_led"}, {8'h00, Led}, {8'h00, e.a});
            if (disp) check_disp(tag, e.acc);
        end
    endtask

    initial begin
        btn   = 4'b0001;
        sw    = 8'h00;
        m_a   = 8'h00;
        m_acc = 16'h0000;

        // Reset held: outputs at cleared state regardless of clocks.
        #3;
        check("rst_led", {8'h00, Led}, 16'h0000);
        check("rst_an", {12'h000, an}, 16'h000E);
        check("rst_seg", {9'h000, seg}, 16'h0040);
        check("rst_dp", {15'h0000, dp}, 16'h0001);
        tick();
        tick();
        check("rst_hold_an", {12'h000, an}, 16'h000E);
        btn = 4'b0000;
        tick();
        check_disp("rst_disp", 16'h0000);

        // Load 01, add once.
        sw = 8'h01;
        press("ld01", 1'b1, 1'b0, 1, 1'b0);
        press("add01", 1'b0, 1'b1, 1, 1'b1);

        // FF loaded, two adds -> 01FE.
        do_reset();
        sw = 8'hFF;
        press("ldff", 1'b1, 1'b0, 1, 1'b0);
        press("addff_1", 1'b0, 1'b1, 1, 1'b0);
        press("addff_2", 1'b0, 1'b1, 1, 1'b1);

        // Held ADD counts once.
        do_reset();
        sw = 8'h03;
        press("ld03", 1'b1, 1'b0, 1, 1'b0);
        press("hold_add", 1'b0, 1'b1, 5, 1'b1);

        // Wrap: 257 adds of FF -> FFFF, one more -> 00FE.
        do_reset();
        sw = 8'hFF;
        press("ldwrap", 1'b1, 1'b0, 1, 1'b0);
        for (int i = 0; i < 257; i++) press("wrap_add", 1'b0, 1'b1, 1, 1'b0);
        check_disp("wrap_ffff", 16'hFFFF);
        press("wrap_over", 1'b0, 1'b1, 1, 1'b1);

        // LOAD and ADD together: LOAD wins, ACC untouched.
        do_reset();
        sw = 8'h01;
        press("ld01b", 1'b1, 1'b0, 1, 1'b0);
        for (int i = 0; i < 16; i++) press("to10", 1'b0, 1'b1, 1, 1'b0);
        check_disp("acc10", 16'h0010);
        sw = 8'h05;
        press("both", 1'b1, 1'b1, 1, 1'b1);

        // Switch changes alone never move A or ACC.
        sw = 8'hA5;
        tick();
        tick();
        check("sw_only_led", {8'h00, Led}, 16'h0005);
        check_disp("sw_only", 16'h0010);

        // Build ACC=1234, then assert reset between edges.
        do_reset();
        sw = 8'hFF;
        press("ld_ff3", 1'b1, 1'b0, 1, 1'b0);
        for (int i = 0; i < 18; i++) press("to11ee", 1'b0, 1'b1, 1, 1'b0);
        sw = 8'h46;
        press("ld46", 1'b1, 1'b0, 1, 1'b0);
        press("to1234", 1'b0, 1'b1, 1, 1'b1);
        @(posedge MCLK);
        #2;
        btn[0] = 1'b1;
        #1;
        check("async_led", {8'h00, Led}, 16'h0000);
        check("async_an", {12'h000, an}, 16'h000E);
        check("async_seg", {9'h000, seg}, 16'h0040);
        @(negedge MCLK);
        btn[0] = 1'b0;
        m_a   = 8'h00;
        m_acc = 16'h0000;
        tick();
        check_disp("async_disp", 16'h0000);

        // LOAD held through reset release must not fire until re-pressed.
        sw = 8'h09;
        btn = 4'b0011;
        tick();
        btn[0] = 1'b0;
        repeat (3) tick();
        check("held_ld_led", {8'h00, Led}, 16'h0000);
        btn[1] = 1'b0;
        tick();
        check("released_led", {8'h00, Led}, 16'h0000);
        press("repress", 1'b1, 1'b0, 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
